// File: rtl/tick_counter.sv
// Modulo-(max_val+1) up/down counter of rising edges on a divider output
// that is sampled as a level in the clk domain.
module tick_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick_in,
    input  logic         en,
    input  logic         up_dn,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic [W-1:0] max_val,
    input  logic         clr_flag,
    output logic [W-1:0] count,
    output logic         edge_seen,
    output logic         wrap,
    output logic         wrap_flag
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic         r_tick_d;
    logic [W-1:0] r_count;
    logic         r_edge_seen;
    logic         r_wrap;
    logic         r_wrap_flag;

    logic         w_edge;
    logic         w_wrap;
    logic [W-1:0] w_count_nxt;

    assign w_edge = tick_in & ~r_tick_d;

    // Compare before increment, so count+1 never overflows; a count already
    // above a freshly lowered max_val wraps on the next up edge.
    always_comb begin
        w_count_nxt = r_count;
        w_wrap      = 1'b0;
        if (ld) begin
            w_count_nxt = (ld_val > max_val) ? max_val : ld_val;
        end else if (w_edge && en) begin
            if (up_dn) begin
                if (r_count >= max_val) begin
                    w_count_nxt = '0;
                    w_wrap      = 1'b1;
                end else begin
                    w_count_nxt = r_count + ONE;
                end
            end else begin
                if (r_count == '0) begin
                    w_count_nxt = max_val;
                    w_wrap      = 1'b1;
                end else begin
                    w_count_nxt = r_count - ONE;
                end
            end
        end
    end

    // tick_d resets high so a level already high at reset release is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_d    <= 1'b1;
            r_count     <= '0;
            r_edge_seen <= 1'b0;
            r_wrap      <= 1'b0;
            r_wrap_flag <= 1'b0;
        end else begin
            r_tick_d    <= tick_in;
            r_count     <= w_count_nxt;
            r_edge_seen <= w_edge;
            r_wrap      <= w_wrap;
            if (w_wrap)
                r_wrap_flag <= 1'b1;
            else if (clr_flag)
                r_wrap_flag <= 1'b0;
        end
    end

    assign count     = r_count;
    assign edge_seen = r_edge_seen;
    assign wrap      = r_wrap;
    assign wrap_flag = r_wrap_flag;

endmodule

// File: tb/tb_tick_counter.sv
// Table-driven bench for tick_counter: one vector per clk cycle, expected
// outputs queued as each vector is driven and compared after the edge.
module tb_tick_counter;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick_in;
    logic         en;
    logic         up_dn;
    logic         ld;
    logic [W-1:0] ld_val;
    logic [W-1:0] max_val;
    logic         clr_flag;
    logic [W-1:0] count;
    logic         edge_seen;
    logic         wrap;
    logic         wrap_flag;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic         tick;
        logic         en;
        logic         up;
        logic         ld;
        logic [W-1:0] ldv;
        logic [W-1:0] mx;
        logic         clr;
        logic [W-1:0] c;
        logic         e;
        logic         w;
        logic         f;
        string        name;
    } vec_t;

    typedef struct {
        logic [W-1:0] c;
        logic         e;
        logic         w;
        logic         f;
        string        name;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    tick_counter #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_in   (tick_in),
        .en        (en),
        .up_dn     (up_dn),
        .ld        (ld),
        .ld_val    (ld_val),
        .max_val   (max_val),
        .clr_flag  (clr_flag),
        .count     (count),
        .edge_seen (edge_seen),
        .wrap      (wrap),
        .wrap_flag (wrap_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic t, input logic en_i, input logic up,
                       input logic l, input logic [W-1:0] lv, input logic [W-1:0] mx,
                       input logic cl, input logic [W-1:0] c, input logic e,
                       input logic w, input logic f);
        vec_t v;
        v.tick = t;  v.en = en_i; v.up = up; v.ld = l; v.ldv = lv; v.mx = mx;
        v.clr = cl;  v.c = c;     v.e = e;   v.w = w;  v.f = f;   v.name = n;
        tbl.push_back(v);
    endtask

    task automatic run_table();
        exp_t x;
        exp_t got;
        for (int i = 0; i < tbl.size(); i++) begin
            tick_in  = tbl[i].tick;
            en       = tbl[i].en;
            up_dn    = tbl[i].up;
            ld       = tbl[i].ld;
            ld_val   = tbl[i].ldv;
            max_val  = tbl[i].mx;
            clr_flag = tbl[i].clr;
            x.c = tbl[i].c; x.e = tbl[i].e; x.w = tbl[i].w; x.f = tbl[i].f;
            x.name = $sformatf("%s[%0d]", tbl[i].name, i);
            sb.push_back(x);
            @(posedge clk);
            #1;
            got = sb.pop_front();
            chk({got.name, ".count"},     count,              got.c);
            chk({got.name, ".edge_seen"}, {15'd0, edge_seen}, {15'd0, got.e});
            chk({got.name, ".wrap"},      {15'd0, wrap},      {15'd0, got.w});
            chk({got.name, ".wrap_flag"}, {15'd0, wrap_flag}, {15'd0, got.f});
        end
        tbl.delete();
    endtask

    task automatic check_zero(input string n);
        chk({n, ".count"},     count,              16'd0);
        chk({n, ".edge_seen"}, {15'd0, edge_seen}, 16'd0);
        chk({n, ".wrap"},      {15'd0, wrap},      16'd0);
        chk({n, ".wrap_flag"}, {15'd0, wrap_flag}, 16'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; tick_in = 1'b0; en = 1'b0; up_dn = 1'b1; ld = 1'b0;
        ld_val = '0; max_val = '0; clr_flag = 1'b0;
        @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
    endtask

    logic [W-1:0] up_seq [5] = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
    logic [W-1:0] dn_seq [4] = '{16'd2, 16'd1, 16'd0, 16'd2};

    initial begin
        do_reset();

        // up count with wrap, tick period 4
        add("up_idle", 0, 1, 1, 0, 0, 3, 0, 0, 0, 0, 0);
        for (int e = 0; e < 5; e++) begin
            add("up_edge", 1, 1, 1, 0, 0, 3, 0, up_seq[e], 1, (e == 3), (e >= 3));
            for (int k = 0; k < 3; k++)
                add("up_low", 0, 1, 1, 0, 0, 3, 0, up_seq[e], 0, 0, (e >= 3));
        end
        add("up_clr", 0, 1, 1, 0, 0, 3, 1, 1, 0, 0, 0);
        run_table();

        // down count with reload from reset
        do_reset();
        add("dn_idle", 0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0);
        for (int e = 0; e < 4; e++) begin
            add("dn_edge", 1, 1, 0, 0, 0, 2, 0, dn_seq[e], 1, (e == 0 || e == 3), 1);
            add("dn_low",  0, 1, 0, 0, 0, 2, 0, dn_seq[e], 0, 0, 1);
        end
        run_table();

        // load priority and clamp
        add("ld_set1",   0, 1, 0, 1, 1, 5, 1, 1, 0, 0, 0);
        add("ld_clamp",  1, 1, 0, 1, 9, 5, 0, 5, 1, 0, 0);
        add("ld_low",    0, 1, 0, 0, 0, 5, 0, 5, 0, 0, 0);
        add("ld_upwrap", 1, 1, 1, 0, 0, 5, 0, 0, 1, 1, 1);
        add("ld_low2",   0, 1, 1, 0, 0, 5, 0, 0, 0, 0, 1);
        run_table();

        // enable gating, then a held level
        for (int k = 0; k < 3; k++) begin
            add("en0_edge", 1, 0, 1, 0, 0, 5, 0, 0, 1, 0, 1);
            add("en0_low",  0, 0, 1, 0, 0, 5, 0, 0, 0, 0, 1);
        end
        add("held_first", 1, 1, 1, 0, 0, 5, 0, 1, 1, 0, 1);
        for (int k = 0; k < 9; k++)
            add("held_high", 1, 1, 1, 0, 0, 5, 0, 1, 0, 0, 1);
        add("held_low", 0, 1, 1, 0, 0, 5, 0, 1, 0, 0, 1);
        run_table();

        // reset corners: async assertion mid-count with edge_seen high
        add("rc_ld7",  0, 1, 1, 1, 7, 20, 0, 7, 0, 0, 1);
        add("rc_edge", 1, 1, 1, 0, 0, 20, 0, 8, 1, 0, 1);
        run_table();
        #2;
        rst = 1'b1;
        tick_in = 1'b1;
        #1;
        check_zero("rst_async");
        @(posedge clk);
        #1;
        check_zero("rst_held");
        rst = 1'b0;
        add("rc_hi_first", 1, 1, 1, 0, 0, 20, 0, 0, 0, 0, 0);
        add("rc_hi_again", 1, 1, 1, 0, 0, 20, 0, 0, 0, 0, 0);
        add("rc_low",      0, 1, 1, 0, 0, 20, 0, 0, 0, 0, 0);
        add("rc_edge1",    1, 1, 1, 0, 0, 20, 0, 1, 1, 0, 0);
        add("rc_low2",     0, 1, 1, 0, 0, 20, 0, 1, 0, 0, 0);
        run_table();

        // modulus lowered below count: up wraps, down just decrements
        add("mv_ld8",   0, 1, 1, 1, 8,  20, 0, 8,  0, 0, 0);
        add("mv_upwr",  1, 1, 1, 0, 0,  4,  0, 0,  1, 1, 1);
        add("mv_low",   0, 1, 1, 0, 0,  4,  0, 0,  0, 0, 1);
        add("mv_ld10",  0, 1, 0, 1, 10, 20, 1, 10, 0, 0, 0);
        add("mv_dn",    1, 1, 0, 0, 0,  4,  0, 9,  1, 0, 0);
        add("mv_low2",  0, 1, 0, 0, 0,  4,  0, 9,  0, 0, 0);
        run_table();

        // max_val = 0, set-wins on coincident clr_flag
        add("m0_ld", 0, 1, 1, 1, 5, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            add("m0_edge", 1, 1, (k < 2), 0, 0, 0, (k == 1), 0, 1, 1, 1);
            add("m0_low",  0, 1, (k < 2), 0, 0, 0, 0,        0, 0, 0, 1);
        end
        add("m0_clr", 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        run_table();

        // full-width natural wrap
        add("fw_ld",   0, 1, 1, 1, 16'hFFFE, 16'hFFFF, 0, 16'hFFFE, 0, 0, 0);
        add("fw_e1",   1, 1, 1, 0, 0,        16'hFFFF, 0, 16'hFFFF, 1, 0, 0);
        add("fw_low",  0, 1, 1, 0, 0,        16'hFFFF, 0, 16'hFFFF, 0, 0, 0);
        add("fw_e2",   1, 1, 1, 0, 0,        16'hFFFF, 0, 16'h0000, 1, 1, 1);
        add("fw_low2", 0, 1, 1, 0, 0,        16'hFFFF, 0, 16'h0000, 0, 0, 1);
        run_table();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
